// File: rtl/branch_sched.sv
// Branch resolution controller: owns the NZCV flag register, tracks in-flight
// flag writers, resolves one branch at a time and sequences redirect/flush.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | ready for a branch request
// WAIT_FLAGS | flag-based branch held until no flag writer is in flight
// RESOLVE    | condition evaluated from latched operands and flags
// REDIRECT   | taken branch: redirect pulse, flush held FLUSH_CYCLES cycles
module branch_sched #(
    parameter int WIDTH        = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int PEND_W       = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [3:0]       br_cond,
    input  logic [WIDTH-1:0] br_r2,
    input  logic [WIDTH-1:0] br_r3,
    input  logic [WIDTH-1:0] br_target,
    input  logic             flag_issue,
    input  logic             flag_we,
    input  logic [3:0]       flag_nzcv,
    output logic [3:0]       flags,
    output logic             stall,
    output logic             resolve_done,
    output logic             resolve_taken,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             flush
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FLAGS = 2'd1,
        RESOLVE    = 2'd2,
        REDIRECT   = 2'd3
    } state_t;

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t            state;
    logic [3:0]        cond_q;
    logic [WIDTH-1:0]  r2_q;
    logic [WIDTH-1:0]  r3_q;
    logic [PEND_W-1:0] pend;
    logic [FC_W-1:0]   fcnt;
    logic              taken;

    function automatic logic is_flag_cond(input logic [3:0] c);
        return (c == 4'b0110) || (c == 4'b0111) || (c == 4'b1000) ||
               (c == 4'b1010) || (c == 4'b1011);
    endfunction

    // flags are {N,Z,C,V}
    function automatic logic eval_cond(input logic [3:0] c,
                                       input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b,
                                       input logic [3:0] f);
        logic r;
        r = 1'b0;
        case (c)
            4'b0001: r = (a == b);
            4'b0010: r = ($signed(a) < $signed(b));
            4'b0011: r = (a < b);
            4'b0100: r = (a != b);
            4'b0101: r = ($signed(a) >= $signed(b));
            4'b0110: r = f[1] & ~f[2];
            4'b0111: r = ~f[1] | f[2];
            4'b1000: r = f[1];
            4'b1001: r = 1'b1;
            4'b1010: r = f[3];
            4'b1011: r = f[0];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign taken    = eval_cond(cond_q, r2_q, r3_q, flags);
    assign br_ready = (state == IDLE);
    assign stall    = (state == WAIT_FLAGS) || (state == RESOLVE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cond_q         <= '0;
            r2_q           <= '0;
            r3_q           <= '0;
            pend           <= '0;
            fcnt           <= '0;
            flags          <= '0;
            resolve_done   <= 1'b0;
            resolve_taken  <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
        end else begin
            if (flag_we)
                flags <= flag_nzcv;

            // issue and writeback in the same cycle cancel out
            if (flag_issue && !flag_we && pend != PEND_MAX)
                pend <= pend + 1'b1;
            else if (flag_we && !flag_issue && pend != '0)
                pend <= pend - 1'b1;

            resolve_done   <= 1'b0;
            redirect_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (br_valid) begin
                        cond_q      <= br_cond;
                        r2_q        <= br_r2;
                        r3_q        <= br_r3;
                        redirect_pc <= br_target;
                        if (is_flag_cond(br_cond) && (pend != '0 || flag_issue))
                            state <= WAIT_FLAGS;
                        else
                            state <= RESOLVE;
                    end
                end
                WAIT_FLAGS: begin
                    if (pend == '0 && !flag_issue)
                        state <= RESOLVE;
                end
                RESOLVE: begin
                    resolve_done  <= 1'b1;
                    resolve_taken <= taken;
                    if (taken) begin
                        redirect_valid <= 1'b1;
                        flush          <= 1'b1;
                        fcnt           <= FC_W'(FLUSH_CYCLES - 1);
                        state          <= REDIRECT;
                    end else begin
                        state <= IDLE;
                    end
                end
                REDIRECT: begin
                    if (fcnt == '0) begin
                        flush <= 1'b0;
                        state <= IDLE;
                    end else begin
                        fcnt <= fcnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
